// File: rtl/clk_divider_prog_if.sv
// clk_divider_prog_if: control/load handshake and divided outputs of the programmable clock divider
interface clk_divider_prog_if #(parameter int WIDTH = 8);
    logic             en;
    logic             sync;
    logic             load_valid;
    logic [WIDTH-1:0] load_div;
    logic             load_ready;
    logic [WIDTH-1:0] cur_div;
    logic             clk_out;
    logic             tick;
    modport master(output en, sync, load_valid, load_div, input load_ready, cur_div, clk_out, tick);
    modport slave(input en, sync, load_valid, load_div, output load_ready, cur_div, clk_out, tick);
endinterface

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable divider; a new divisor only takes effect at a period boundary
module clk_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input logic                 clk,
    input logic                 reset,
    clk_divider_prog_if.slave   bus
);
    typedef enum logic {STOPPED, RUN} state_t;
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_cur;
    logic [WIDTH-1:0] pend_div;
    logic             pend_valid;
    logic             clk_out_r;
    logic             tick_r;
    logic             accept;
    logic             boundary;
    logic [WIDTH-1:0] load_clamped;
    always_comb begin
        accept       = bus.load_valid && !pend_valid;
        load_clamped = (bus.load_div < MIN_DIV) ? MIN_DIV : bus.load_div;
        boundary     = (cnt == div_cur - WIDTH'(1)) || bus.sync;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STOPPED;
            cnt        <= '0;
            div_cur    <= DEF_DIV;
            pend_div   <= DEF_DIV;
            pend_valid <= 1'b0;
            clk_out_r  <= 1'b0;
            tick_r     <= 1'b0;
        end else if (state == STOPPED) begin
            cnt       <= '0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            if (accept)
                div_cur <= load_clamped;
            if (bus.en)
                state <= RUN;
        end else if (!bus.en) begin
            // stopping: whatever divisor is waiting becomes current immediately
            state      <= STOPPED;
            cnt        <= '0;
            clk_out_r  <= 1'b0;
            tick_r     <= 1'b0;
            pend_valid <= 1'b0;
            if (pend_valid)
                div_cur <= pend_div;
            else if (accept)
                div_cur <= load_clamped;
        end else begin
            clk_out_r <= cnt < (div_cur >> 1);
            tick_r    <= cnt == '0;
            cnt       <= boundary ? '0 : cnt + WIDTH'(1);
            // accept only fires with nothing pending, so a same-cycle accept waits for the next boundary
            if (boundary && pend_valid) begin
                div_cur    <= pend_div;
                pend_valid <= 1'b0;
            end
            if (accept) begin
                pend_div   <= load_clamped;
                pend_valid <= 1'b1;
            end
        end
    end
    assign bus.load_ready = !pend_valid;
    assign bus.cur_div    = div_cur;
    assign bus.clk_out    = clk_out_r;
    assign bus.tick       = tick_r;
endmodule
